switch_debounce: RTL



---
 rtl/io_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/switch_debounce.sv | 103 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for board-input conditioning blocks.
package io_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_t;

  // 10 ms of stable input at a 100 MHz system clock
  localparam int unsigned DEB_CYCLES_100MHZ_10MS = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_q1;
  logic r_q2;

  // Metastability filter: q1 captures the raw pin, q2 is the clean copy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= d;
      r_q2 <= r_q1;
    end
  end

  assign q = r_q2;

endmodule

// File: rtl/switch_debounce.sv
// Switch/button conditioner: synchronise, debounce, emit level, edge strobes and toggle.
module switch_debounce
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_100MHZ_10MS
) (
  input  logic clk,
  input  logic rst,
  input  logic switch,
  output logic level,
  output logic rise,
  output logic fall,
  output logic toggle
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_s;
  deb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             r_toggle;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (switch),
    .q   (w_s)
  );

  // Debounce FSM: count consecutive samples differing from the accepted level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= STABLE_LOW;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LOW: begin
          if (w_s) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!w_s) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state  <= STABLE_HIGH;
            r_cnt    <= '0;
            r_level  <= 1'b1;
            r_rise   <= 1'b1;
            r_toggle <= ~r_toggle;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STABLE_HIGH: begin
          if (!w_s) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (w_s) begin
            r_state <= STABLE_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= STABLE_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign level  = r_level;
  assign rise   = r_rise;
  assign fall   = r_fall;
  assign toggle = r_toggle;

endmodule
